// File: rtl/calc_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the accumulator calculator.
// Latency: none (types and constants only).
// Backpressure: none.
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_OR   = 4'h2,
        OP_AND  = 4'h3,
        OP_XOR  = 4'h4,
        OP_LSL1 = 4'h5,
        OP_LSR1 = 4'h6,
        OP_ASR1 = 4'h7,
        OP_NEG  = 4'h8,
        OP_INV  = 4'h9,
        OP_REV  = 4'hA,
        OP_MUL  = 4'hB,
        OP_LOAD = 4'hC,
        OP_LT   = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } op_e;

    // Bit positions inside the 3-bit {C, N, Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per enabled cycle.
// Latency: WIDTH enabled cycles after start; o_done is high in the cycle whose edge commits the last step.
// Backpressure: i_en low freezes counter and partial product; start is ignored by design while busy.
module calc_mul_seq #(
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_lo,
    output logic             o_prod_hi_nz
);

    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   w_prod_nxt;

    // Next partial product; the product outputs look one step ahead so the
    // final step can be committed by the parent on the same edge.
    assign w_prod_nxt   = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign o_prod_lo    = w_prod_nxt[WIDTH-1:0];
    assign o_prod_hi_nz = |w_prod_nxt[2*WIDTH-1:WIDTH];
    assign o_busy       = r_busy;
    assign o_done       = r_busy & i_en & (r_cnt == CW'(WIDTH - 1));

    // Operand capture on start, then one shift-add step per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (i_start && !r_busy) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
        end else if (r_busy && i_en) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_accum_core.sv
// Multi-accumulator calculator: one opcode per strobe rise, ALU ops single cycle, MUL via shift-add sequencer.
// Latency: ALU ops commit on the rise edge; MUL commits WIDTH enabled cycles later; done_o pulses the cycle after commit.
// Backpressure: none queued; a strobe rise while busy_o is high is silently dropped.
module calc_accum_core
    import calc_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NREGS = 4,
    localparam int SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             strobe_i,
    input  logic [3:0]       op_i,
    input  logic [SELW-1:0]  sel_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] result_o,
    output logic [2:0]       flags_o,
    output logic             busy_o,
    output logic             done_o
);

    logic [WIDTH-1:0] r_acc [NREGS];
    logic             r_strobe_q;
    logic [2:0]       r_flags;
    logic             r_done;
    logic [SELW-1:0]  r_sel_lat;
    state_e           r_state;
    state_e           w_state_nxt;

    op_e              w_op;
    logic             w_rise;
    logic             w_mul_start;
    logic             w_alu_go;
    logic             w_mul_done;
    logic             w_seq_busy;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c;
    logic             w_wr;
    logic [WIDTH-1:0] w_prod_lo;
    logic             w_prod_hi_nz;
    logic [2:0]       w_flags_alu;
    logic [2:0]       w_flags_mul;

    assign w_op     = op_e'(op_i);
    assign w_rise   = strobe_i & ~r_strobe_q & ena;
    assign w_a      = r_acc[sel_i];
    assign result_o = r_acc[sel_i];
    assign flags_o  = r_flags;
    assign done_o   = r_done;

    calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (ena),
        .i_start      (w_mul_start),
        .i_a          (w_a),
        .i_b          (operand_i),
        .o_busy       (w_seq_busy),
        .o_done       (w_mul_done),
        .o_prod_lo    (w_prod_lo),
        .o_prod_hi_nz (w_prod_hi_nz)
    );

    // Single-cycle ALU: result, carry/compare bit and whether acc is written
    always_comb begin
        w_res = w_a;
        w_c   = 1'b0;
        w_wr  = 1'b1;
        w_sum = {1'b0, w_a} + {1'b0, operand_i};
        case (w_op)
            OP_ADD:  begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
            OP_SUB:  begin w_res = w_a - operand_i; w_c = (w_a < operand_i); end
            OP_OR:   w_res = w_a | operand_i;
            OP_AND:  w_res = w_a & operand_i;
            OP_XOR:  w_res = w_a ^ operand_i;
            OP_LSL1: begin w_res = {w_a[WIDTH-2:0], 1'b0}; w_c = w_a[WIDTH-1]; end
            OP_LSR1: begin w_res = {1'b0, w_a[WIDTH-1:1]}; w_c = w_a[0]; end
            OP_ASR1: begin w_res = {w_a[WIDTH-1], w_a[WIDTH-1:1]}; w_c = w_a[0]; end
            OP_NEG:  w_res = '0 - w_a;
            OP_INV:  w_res = ~w_a;
            OP_REV:  begin
                for (int i = 0; i < WIDTH; i++) begin
                    w_res[i] = w_a[WIDTH-1-i];
                end
            end
            OP_LOAD: w_res = operand_i;
            OP_LT:   begin w_wr = 1'b0; w_c = ($signed(w_a) <  $signed(operand_i)); end
            OP_GT:   begin w_wr = 1'b0; w_c = ($signed(w_a) >  $signed(operand_i)); end
            OP_EQ:   begin w_wr = 1'b0; w_c = (w_a == operand_i); end
            default: w_wr = 1'b0;  // MUL is written back by the sequencer path
        endcase
    end

    // Flag vectors for the two commit paths; compares see the unchanged A in w_res
    always_comb begin
        w_flags_alu         = '0;
        w_flags_alu[FLAG_Z] = (w_res == '0);
        w_flags_alu[FLAG_N] = w_res[WIDTH-1];
        w_flags_alu[FLAG_C] = w_c;
        w_flags_mul         = '0;
        w_flags_mul[FLAG_Z] = (w_prod_lo == '0);
        w_flags_mul[FLAG_N] = w_prod_lo[WIDTH-1];
        w_flags_mul[FLAG_C] = w_prod_hi_nz;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enter MUL on an accepted MUL rise, leave on sequencer completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rise && (w_op == OP_MUL)) w_state_nxt = MUL;
            MUL:     if (w_mul_done)                 w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: commands are only accepted in IDLE, so rises during MUL are dropped
    always_comb begin
        w_mul_start = (r_state == IDLE) & w_rise & (w_op == OP_MUL);
        w_alu_go    = (r_state == IDLE) & w_rise & (w_op != OP_MUL);
        busy_o      = w_seq_busy;
    end

    // Register file: ALU write to the live select, MUL write to the select latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_alu_go && w_wr) begin
            r_acc[sel_i] <= w_res;
        end else if (w_mul_done) begin
            r_acc[r_sel_lat] <= w_prod_lo;
        end
    end

    // Strobe history, MUL target latch, flags and the commit pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
            r_sel_lat  <= '0;
            r_flags    <= '0;
            r_done     <= 1'b0;
        end else begin
            if (ena) begin
                r_strobe_q <= strobe_i;
            end
            if (w_mul_start) begin
                r_sel_lat <= sel_i;
            end
            if (w_alu_go) begin
                r_flags <= w_flags_alu;
            end else if (w_mul_done) begin
                r_flags <= w_flags_mul;
            end
            r_done <= w_alu_go | w_mul_done;
        end
    end

endmodule

// File: doc/calc_accum_core.md
Name: calc_accum_core

Overview:
Parametrised successor to the 8-bit single-accumulator calculator. It holds NREGS accumulators of WIDTH bits and executes one opcode per rising edge of a command strobe. The opcode set is the existing ALU/shift/compare set plus LOAD and a multi-cycle shift-add MUL. It sits behind the chip-top pin wrapper, which maps ui_in/uio_in to operand, opcode, select and strobe.

Parameters:
WIDTH, 8, datapath and accumulator width (>=4)
NREGS, 4, number of accumulators (power of 2, >=1); SELW = max(1, $clog2(NREGS))

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, no command is accepted and all state holds
strobe_i  in  1  command strobe; a command is issued on each 0->1 transition
op_i  in  4  opcode (calc_pkg::op_e), sampled on the strobe rise
sel_i  in  SELW  accumulator select; sampled with the command, also drives the read mux
operand_i  in  WIDTH  operand B, sampled on the strobe rise
result_o  out  WIDTH  acc[sel_i], combinational read of the register file
flags_o  out  3  {C, N, Z} from the last committed op (registered)
busy_o  out  1  high while a MUL is in flight
done_o  out  1  one-cycle pulse after every command commit

Behaviour:
- Reset (async, rst_n=0):
  - all acc = 0, flags_o = 0, busy_o = 0, done_o = 0, strobe history = 0, FSM = IDLE.
  - Takes effect immediately, including mid-MUL.
- Strobe:
  - strobe_q registers strobe_i whenever ena=1; rise = strobe_i & ~strobe_q & ena.
  - Holding strobe high issues exactly one command.
  - A rise while busy_o=1 is dropped: no queueing, no error.
- Opcodes, A = acc[sel], result written back to acc[sel]:
  - 0 ADD: C = carry out.
  - 1 SUB: C = borrow (A < B unsigned).
  - 2 OR, 3 AND, 4 XOR: C = 0.
  - 5 LSL1, 6 LSR1, 7 ASR1: operand ignored; C = bit shifted out.
  - 8 NEG: two's complement; C = 0.
  - 9 INV: C = 0.
  - A REV: bit-reverse; C = 0.
  - B MUL: low WIDTH bits of A*B; C = 1 iff the high half is nonzero.
  - C LOAD: A = B; C = 0.
  - D LT, E GT, F EQ: signed compare of A against B; acc not written; C = compare result; Z and N reflect the unchanged A.
- Flags for all other ops: Z = (result == 0), N = result[WIDTH-1]. All widths use WIDTH-bit modular arithmetic.
- Single-cycle ops:
  - Rise detected at edge k; acc, flags commit at edge k.
  - done_o = 1 between edges k and k+1.
  - result_o reflects the new value after edge k.
- FSM IDLE / MUL:
  - IDLE -> MUL on a MUL rise at edge k. Capture A, B and sel into calc_mul_seq; busy_o = 1 from edge k.
  - One shift-add iteration per enabled cycle. The final iteration commits at edge k+WIDTH.
  - On commit: acc[sel_latched] written, flags updated, busy_o = 0, done_o pulses for one cycle, return to IDLE.
  - sel_i changes during MUL affect only result_o, never the write target.
  - ena=0 during MUL freezes the iteration counter and partial product; they resume when ena returns.
- Commands and strobes do not interact across registers: a write touches only acc[sel].

Decomposition:
- calc_pkg holds:
  - op_e enum (4-bit, values 0x0-0xF as above).
  - Flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2.
  - state_e {IDLE, MUL}.
- Sub-module calc_mul_seq, parametrised by WIDTH:
  - start/a/b in; busy/done/prod_lo/prod_hi_nz out.
  - Iterative shift-add with a $clog2(WIDTH)+1 counter and the same clk/rst_n.
- Top holds the register file, strobe edge detect, single-cycle ALU, flag register and FSM.

Test Plan:
All scenarios use WIDTH=8, NREGS=4.
1. Reset; LOAD 0x7F to r0; ADD 0x01 -> result_o=0x80, flags C=0 N=1 Z=0, done_o high exactly 1 cycle.
2. r0=0x01; ADD 0xFF -> 0x00, C=1 Z=1. Then LSR1 on r0 loaded with 0x81 -> 0x40, C=1. Then ASR1 on 0x80 -> 0xC0, N=1.
3. LOAD r1=0x0D; MUL 0x0B -> busy_o high 8 cycles, r1=0x8F, C=0. Then r1=0x20, MUL 0x10 -> r1=0x00, C=1 Z=1. r0, r2, r3 unchanged.
4. Hold strobe_i high 5 cycles with ADD 0x01 -> r0 increments once. A strobe pulse during a MUL -> dropped, no done_o, acc unchanged.
5. r0=0x00: LT 0x7F -> C=1; LT 0xFF -> C=0; GT 0xFF -> C=1; EQ 0x00 -> C=1, Z=1; r0 stays 0x00 throughout.
6. Start MUL, assert rst_n low at cycle 3 -> busy_o=0, all acc=0, flags=0 immediately. After release, a new ADD executes normally.
